// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared constants, types and helpers for the fetch stage
package pc_fetch_unit_pkg;

    localparam int          WORD_W           = 32;
    localparam int          COUNT_W          = 16;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [15:0] COUNT_MAX        = 16'hFFFF;

    // What the fetch stage does on the coming edge, after priority resolution.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_action_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
        logic              valid;
    } if_id_t;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

    function automatic fetch_action_e resolve_action(input logic select, input logic stall);
        if (select)
            return ACT_REDIRECT;
        else if (stall)
            return ACT_STALL;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch stage bus: redirect/stall controls, imem read, IF/ID outputs
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic               select;
    logic [WORD_W-1:0]  branch_target;
    logic               stall;
    logic [WORD_W-1:0]  instr_in;
    logic [WORD_W-1:0]  pc;
    logic [WORD_W-1:0]  if_id_instr;
    logic [WORD_W-1:0]  if_id_pc_plus4;
    logic               if_id_valid;
    logic               flush;
    logic [COUNT_W-1:0] redirect_count;

    // master: the pipeline control / instruction memory side
    modport master (
        output select, branch_target, stall, instr_in,
        input  pc, if_id_instr, if_id_pc_plus4, if_id_valid, flush, redirect_count
    );

    // slave: the fetch unit itself
    modport slave (
        input  select, branch_target, stall, instr_in,
        output pc, if_id_instr, if_id_pc_plus4, if_id_valid, flush, redirect_count
    );

endinterface

// File: rtl/pc_fetch_unit_if_id_reg.sv
// rtl/pc_fetch_unit_if_id_reg.sv - IF/ID pipeline register with hold and bubble controls
module if_id_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t empty_entry;

    assign empty_entry = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

    // bubble beats hold: a flushed slot must never keep a wrong-path instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= empty_entry;
        end else if (bubble) begin
            q <= empty_entry;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, next-PC selection, IF/ID register and redirect counter
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] NOP_INSTR = pc_fetch_unit_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_fetch_unit_if.slave        fetch
);

    fetch_action_e      action;
    logic [WORD_W-1:0]  pc_reg;
    logic [WORD_W-1:0]  pc_plus4;
    logic [WORD_W-1:0]  redirect_pc;
    logic               flush_reg;
    logic [COUNT_W-1:0] count_reg;
    if_id_t             if_id_d;
    if_id_t             if_id_q;
    logic               if_id_hold;
    logic               if_id_bubble;

    always_comb begin
        action       = resolve_action(fetch.select, fetch.stall);
        pc_plus4     = pc_reg + PC_STEP;
        redirect_pc  = align_word(fetch.branch_target);
        if_id_hold   = (action == ACT_STALL);
        if_id_bubble = (action == ACT_REDIRECT);
        if_id_d      = '{instr: fetch.instr_in, pc_plus4: pc_plus4, valid: 1'b1};
    end

    // PC wraps silently at 2^32; redirect targets are forced word-aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            flush_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            case (action)
                ACT_REDIRECT: begin
                    pc_reg    <= redirect_pc;
                    flush_reg <= 1'b1;
                    if (count_reg != COUNT_MAX)
                        count_reg <= count_reg + 16'd1;
                end
                ACT_STALL: begin
                    flush_reg <= 1'b0;
                end
                default: begin
                    pc_reg    <= pc_plus4;
                    flush_reg <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .hold   (if_id_hold),
        .bubble (if_id_bubble),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign fetch.pc             = pc_reg;
    assign fetch.if_id_instr    = if_id_q.instr;
    assign fetch.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign fetch.if_id_valid    = if_id_q.valid;
    assign fetch.flush          = flush_reg;
    assign fetch.redirect_count = count_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_NOP      = 32'h0000_0000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC  (T_RESET_PC),
        .NOP_INSTR (T_NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fetch (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return {addr[7:0], addr[31:8]} ^ 32'h1357_9BDF;
    endfunction

    always_comb bus.instr_in = instr_of(bus.pc);

    // reference state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_flush;
    int          m_cnt;

    function automatic void model_step(input logic r, input logic sel, input logic stl,
                                       input logic [31:0] tgt);
        if (r) begin
            m_pc = T_RESET_PC; m_instr = T_NOP; m_pc4 = 0; m_valid = 0; m_flush = 0; m_cnt = 0;
        end else if (sel) begin
            m_pc = (tgt / 4) * 4;
            m_instr = T_NOP; m_pc4 = 0; m_valid = 0; m_flush = 1;
            m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end else if (stl) begin
            m_flush = 0;
        end else begin
            m_instr = instr_of(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1; m_flush = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},     bus.pc,                 m_pc);
        check({tag, ".instr"},  bus.if_id_instr,        m_instr);
        check({tag, ".pc4"},    bus.if_id_pc_plus4,     m_pc4);
        check({tag, ".valid"},  {31'd0, bus.if_id_valid}, {31'd0, m_valid});
        check({tag, ".flush"},  {31'd0, bus.flush},     {31'd0, m_flush});
        check({tag, ".count"},  {16'd0, bus.redirect_count}, m_cnt[31:0]);
    endtask

    task automatic drive_edge(input logic r, input logic sel, input logic stl,
                              input logic [31:0] tgt);
        reset = r; bus.select = sel; bus.stall = stl; bus.branch_target = tgt;
        model_step(r, sel, stl, tgt);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, sel, stl;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_valid, e_flush;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic r, input logic sel, input logic stl,
                                input logic [31:0] tgt, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] pc4,
                                input logic v, input logic f, input logic [15:0] c);
        vec_t x;
        x.r = r; x.sel = sel; x.stl = stl; x.tgt = tgt;
        x.e_pc = pc; x.e_instr = ins; x.e_pc4 = pc4; x.e_valid = v; x.e_flush = f; x.e_cnt = c;
        return x;
    endfunction

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; bus.select = 1'b0; bus.stall = 1'b0; bus.branch_target = '0;

        vecs[0]  = mk(1,0,0,0,            32'h0,   T_NOP,                  32'h0,   0,0,0);
        vecs[1]  = mk(0,0,0,0,            32'h4,   instr_of(32'h0),        32'h4,   1,0,0);
        vecs[2]  = mk(0,0,0,0,            32'h8,   instr_of(32'h4),        32'h8,   1,0,0);
        vecs[3]  = mk(0,0,0,0,            32'hC,   instr_of(32'h8),        32'hC,   1,0,0);
        vecs[4]  = mk(0,0,0,0,            32'h10,  instr_of(32'hC),        32'h10,  1,0,0);
        vecs[5]  = mk(0,0,1,0,            32'h10,  instr_of(32'hC),        32'h10,  1,0,0);
        vecs[6]  = mk(0,0,1,0,            32'h10,  instr_of(32'hC),        32'h10,  1,0,0);
        vecs[7]  = mk(0,0,0,0,            32'h14,  instr_of(32'h10),       32'h14,  1,0,0);
        vecs[8]  = mk(0,0,0,0,            32'h18,  instr_of(32'h14),       32'h18,  1,0,0);
        vecs[9]  = mk(0,0,0,0,            32'h1C,  instr_of(32'h18),       32'h1C,  1,0,0);
        vecs[10] = mk(0,0,0,0,            32'h20,  instr_of(32'h1C),       32'h20,  1,0,0);
        vecs[11] = mk(0,1,0,32'h103,      32'h100, T_NOP,                  32'h0,   0,1,1);
        vecs[12] = mk(0,0,0,0,            32'h104, instr_of(32'h100),      32'h104, 1,0,1);
        vecs[13] = mk(0,1,1,32'h200,      32'h200, T_NOP,                  32'h0,   0,1,2);
        vecs[14] = mk(0,0,1,0,            32'h200, T_NOP,                  32'h0,   0,0,2);
        vecs[15] = mk(1,1,0,32'h300,      32'h0,   T_NOP,                  32'h0,   0,0,0);
        vecs[16] = mk(1,0,1,0,            32'h0,   T_NOP,                  32'h0,   0,0,0);
        vecs[17] = mk(0,0,0,0,            32'h4,   instr_of(32'h0),        32'h4,   1,0,0);
        vecs[18] = mk(0,1,0,32'hFFFF_FFFE,32'hFFFF_FFFC, T_NOP,            32'h0,   0,1,1);
        vecs[19] = mk(0,0,0,0,            32'h0,   instr_of(32'hFFFF_FFFC),32'h0,   1,0,1);
        vecs[20] = mk(0,0,0,0,            32'h4,   instr_of(32'h0),        32'h4,   1,0,1);
        vecs[21] = mk(0,1,0,32'h41,       32'h40,  T_NOP,                  32'h0,   0,1,2);
        vecs[22] = mk(0,1,0,32'h82,       32'h80,  T_NOP,                  32'h0,   0,1,3);
        vecs[23] = mk(0,0,0,0,            32'h84,  instr_of(32'h80),       32'h84,  1,0,3);

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            drive_edge(vecs[i].r, vecs[i].sel, vecs[i].stl, vecs[i].tgt);
            check($sformatf("vec%0d.pc", i),    bus.pc,             vecs[i].e_pc);
            check($sformatf("vec%0d.instr", i), bus.if_id_instr,    vecs[i].e_instr);
            check($sformatf("vec%0d.pc4", i),   bus.if_id_pc_plus4, vecs[i].e_pc4);
            check($sformatf("vec%0d.valid", i), {31'd0, bus.if_id_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d.flush", i), {31'd0, bus.flush},       {31'd0, vecs[i].e_flush});
            check($sformatf("vec%0d.count", i), {16'd0, bus.redirect_count}, {16'd0, vecs[i].e_cnt});
        end

        for (int i = 0; i < 2000; i++) begin
            drive_edge(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                       ($urandom_range(4) == 0), $urandom);
            check_model($sformatf("rnd%0d", i));
        end

        drive_edge(1, 0, 0, 0);
        check_model("sat_reset");
        for (int i = 0; i < 65540; i++) begin
            drive_edge(0, 1, ($urandom_range(1) == 1), $urandom);
            if (i < 4 || i >= 65530)
                check_model($sformatf("sat%0d", i));
        end
        check({"sat.final"}, {16'd0, bus.redirect_count}, 32'h0000_FFFF);
        drive_edge(0, 0, 0, 0);
        check_model("sat_release");
        check({"sat.hold"}, {16'd0, bus.redirect_count}, 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000 (sll $0,$0,0), bubble inserted into IF/ID on flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 select  input  1  branch-taken redirect (Branch & zero from MEM stage).
REQ-006 branch_target  input  32  branch target address from EX/MEM register.
REQ-007 stall  input  1  load-use hold request from hazard unit.
REQ-008 instr_in  input  32  instruction word read combinationally from instruction memory at pc.
REQ-009 pc  output  32  current fetch address, drives instruction memory.
REQ-010 if_id_instr  output  32  IF/ID registered instruction.
REQ-011 if_id_pc_plus4  output  32  IF/ID registered PC+4 of that instruction.
REQ-012 if_id_valid  output  1  IF/ID contents are a real, non-flushed instruction.
REQ-013 flush  output  1  registered one-cycle pulse telling ID/EX and EX/MEM registers to bubble.
REQ-014 redirect_count  output  16  number of taken redirects, saturating.

Function
REQ-015 Per-edge priority SHALL be: reset > select > stall > normal advance.
REQ-016 Normal advance: pc <= pc + 4; IF/ID <= {instr_in, pc + 4, valid=1}; flush <= 0.
REQ-017 Redirect (select=1): pc <= {branch_target[31:2], 2'b00}; IF/ID <= {NOP_INSTR, 0, valid=0}; flush <= 1 for exactly one cycle.
REQ-018 Stall (stall=1, select=0): pc and IF/ID SHALL hold; flush <= 0.
REQ-019 select and stall both high: redirect SHALL win; stall ignored that cycle (stalled instruction is wrong-path).
REQ-020 select held high N consecutive cycles: each cycle is a distinct redirect; flush stays high N cycles; counter increments N times.
REQ-021 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000 with no flag.
REQ-022 branch_target bits [1:0] SHALL be discarded; pc[1:0] is always 2'b00.
REQ-023 redirect_count SHALL increment by 1 per redirect cycle and saturate at 16'hFFFF.
REQ-024 Latency: instruction at pc appears on if_id_instr one edge later; redirect target appears on pc one edge after select.
REQ-025 Fully a synchronous design; no output is combinationally dependent on select, stall or instr_in.

Reset
REQ-026 On reset: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, flush=0, redirect_count=0.
REQ-027 reset asserted mid-stall or coincident with select SHALL override both; no redirect counted.
REQ-028 First edge after reset release SHALL fetch RESET_PC and load IF/ID with valid=1 unless stall/select.

Structure
REQ-029 Shared package SHALL hold constants RESET_PC default, NOP_INSTR, PC_STEP=4, and the 32-bit word width.
REQ-030 One sub-module, if_id_reg (IF/ID pipeline register with hold/flush controls), SHALL be instantiated; PC register, adder and redirect counter stay in the top.

Verification
REQ-031 Reset then 4 free-running cycles, stall=0, select=0 -> pc 0x0,0x4,0x8,0xC,0x10; if_id_pc_plus4 lags by one edge; if_id_valid=1 after first edge.
REQ-032 At pc=0x10 assert stall 2 cycles -> pc stays 0x10, IF/ID unchanged, flush=0; resumes 0x14 after release.
REQ-033 At pc=0x20 pulse select with branch_target=0x0000_0103 -> next pc=0x100, if_id_instr=NOP_INSTR, if_id_valid=0, flush=1 one cycle, redirect_count=1.
REQ-034 select=1 and stall=1 same cycle, branch_target=0x200 -> pc=0x200, flush=1 (redirect wins); select=1 and reset=1 -> pc=RESET_PC, redirect_count=0.
REQ-035 Force pc=0xFFFF_FFFC via branch_target, then free-run -> pc=0x0000_0000, no other side effect.
REQ-036 Hold select high 65540 cycles -> redirect_count saturates at 0xFFFF and stays.
